// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, controller states, ALU selects, IR field slices.
package cpu_pkg;

  localparam int PC_W    = 7;
  localparam int INSTR_W = 16;

  typedef enum logic [3:0] {
    OP_NOOP  = 4'h0,
    OP_STORE = 4'h1,
    OP_LOAD  = 4'h2,
    OP_ADD   = 4'h3,
    OP_SUB   = 4'h4,
    OP_HALT  = 4'h5
  } opcode_t;

  typedef enum logic [3:0] {
    S_INIT   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_NOOP   = 4'd3,
    S_LOAD_A = 4'd4,
    S_LOAD_B = 4'd5,
    S_STORE  = 4'd6,
    S_ADD    = 4'd7,
    S_SUB    = 4'd8,
    S_HALT   = 4'd9
  } state_t;

  localparam logic [2:0] ALU_PASS = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_SUB  = 3'b010;

  // IR field positions
  localparam int OPC_MSB  = 15;
  localparam int OPC_LSB  = 12;
  localparam int ADDR_MSB = 11;
  localparam int ADDR_LSB = 4;
  localparam int RA_MSB   = 11;
  localparam int RA_LSB   = 8;
  localparam int RB_MSB   = 7;
  localparam int RB_LSB   = 4;
  localparam int RD_MSB   = 3;
  localparam int RD_LSB   = 0;

  function automatic logic [3:0] ir_opcode(input logic [INSTR_W-1:0] ir);
    return ir[OPC_MSB:OPC_LSB];
  endfunction

  function automatic logic [7:0] ir_addr(input logic [INSTR_W-1:0] ir);
    return ir[ADDR_MSB:ADDR_LSB];
  endfunction

  function automatic logic [3:0] ir_ra(input logic [INSTR_W-1:0] ir);
    return ir[RA_MSB:RA_LSB];
  endfunction

  function automatic logic [3:0] ir_rb(input logic [INSTR_W-1:0] ir);
    return ir[RB_MSB:RB_LSB];
  endfunction

  function automatic logic [3:0] ir_rd(input logic [INSTR_W-1:0] ir);
    return ir[RD_MSB:RD_LSB];
  endfunction

endpackage

// File: rtl/program_counter.sv
// Program counter: synchronous clear, increment enable, wraps at 2^PC_W.
module program_counter #(
  parameter int PC_W = 7
) (
  input  logic            clk,
  input  logic            clr_i,
  input  logic            up_i,
  output logic [PC_W-1:0] count_o
);

  logic [PC_W-1:0] count_q;
  logic [PC_W-1:0] count_d;

  // Next count: clear wins over increment; natural overflow gives the wrap.
  always_comb begin
    count_d = count_q;
    if (clr_i)     count_d = '0;
    else if (up_i) count_d = count_q + PC_W'(1);
  end

  // Count register.
  always_ff @(posedge clk) begin
    count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/control_unit.sv
// Multi-cycle controller: owns PC and IR, sequences fetch/decode/execute and
// drives the Datapath control inputs as Moore outputs of state and IR.
module control_unit
  import cpu_pkg::*;
#(
  parameter int PC_W    = 7,
  parameter int INSTR_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [INSTR_W-1:0] IR_in,
  output logic [PC_W-1:0]    PC_out,
  output logic [INSTR_W-1:0] IR_out,
  output logic [3:0]         state_out,
  output logic [7:0]         D_Addr,
  output logic               D_wr,
  output logic               RF_s,
  output logic [3:0]         RF_W_addr,
  output logic               RF_W_en,
  output logic [3:0]         RF_Ra_addr,
  output logic [3:0]         RF_Rb_addr,
  output logic [2:0]         Alu_s0
);

  state_t             state_q, state_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic               pc_up;

  program_counter #(.PC_W(PC_W)) u_pc (
    .clk     (clk),
    .clr_i   (reset),
    .up_i    (pc_up),
    .count_o (PC_out)
  );

  // State and IR registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_INIT;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  // Next-state logic; IR loads and PC advances only in FETCH.
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    pc_up   = 1'b0;
    case (state_q)
      S_INIT:   state_d = S_FETCH;
      S_FETCH: begin
        ir_d    = IR_in;
        pc_up   = 1'b1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        case (ir_opcode(ir_q))
          OP_STORE: state_d = S_STORE;
          OP_LOAD:  state_d = S_LOAD_A;
          OP_ADD:   state_d = S_ADD;
          OP_SUB:   state_d = S_SUB;
          OP_HALT:  state_d = S_HALT;
          default:  state_d = S_NOOP;
        endcase
      end
      S_NOOP:   state_d = S_FETCH;
      S_LOAD_A: state_d = S_LOAD_B;
      S_LOAD_B: state_d = S_FETCH;
      S_STORE:  state_d = S_FETCH;
      S_ADD:    state_d = S_FETCH;
      S_SUB:    state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_INIT;
    endcase
  end

  // Moore datapath controls decoded from state and IR fields.
  always_comb begin
    D_Addr     = '0;
    D_wr       = 1'b0;
    RF_s       = 1'b0;
    RF_W_addr  = '0;
    RF_W_en    = 1'b0;
    RF_Ra_addr = '0;
    RF_Rb_addr = '0;
    Alu_s0     = ALU_PASS;
    case (state_q)
      S_LOAD_A, S_LOAD_B: begin
        D_Addr    = ir_addr(ir_q);
        RF_s      = 1'b1;
        RF_W_addr = ir_rd(ir_q);
        RF_W_en   = (state_q == S_LOAD_B);
      end
      S_STORE: begin
        D_Addr     = ir_addr(ir_q);
        RF_Ra_addr = ir_rd(ir_q);
        D_wr       = 1'b1;
      end
      S_ADD, S_SUB: begin
        RF_Ra_addr = ir_ra(ir_q);
        RF_Rb_addr = ir_rb(ir_q);
        RF_W_addr  = ir_rd(ir_q);
        RF_W_en    = 1'b1;
        Alu_s0     = (state_q == S_ADD) ? ALU_ADD : ALU_SUB;
      end
      default: ;
    endcase
  end

  assign IR_out    = ir_q;
  assign state_out = state_q;

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: a ROM model feeds IR_in; stimulus pushes the expected
// write-enable transactions, a monitor pops and compares whenever D_wr/RF_W_en fire.
module tb_control_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] IR_in = '0;
  logic [6:0]  PC_out;
  logic [15:0] IR_out;
  logic [3:0]  state_out;
  logic [7:0]  D_Addr;
  logic        D_wr;
  logic        RF_s;
  logic [3:0]  RF_W_addr;
  logic        RF_W_en;
  logic [3:0]  RF_Ra_addr;
  logic [3:0]  RF_Rb_addr;
  logic [2:0]  Alu_s0;

  control_unit #(.PC_W(7), .INSTR_W(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .IR_in      (IR_in),
    .PC_out     (PC_out),
    .IR_out     (IR_out),
    .state_out  (state_out),
    .D_Addr     (D_Addr),
    .D_wr       (D_wr),
    .RF_s       (RF_s),
    .RF_W_addr  (RF_W_addr),
    .RF_W_en    (RF_W_en),
    .RF_Ra_addr (RF_Ra_addr),
    .RF_Rb_addr (RF_Rb_addr),
    .Alu_s0     (Alu_s0)
  );

  always #5 clk = ~clk;

  // Instruction ROM with one-cycle registered read.
  logic [15:0] rom [128];
  always @(posedge clk) IR_in <= rom[PC_out];

  // Cycle index: 0 in INIT right after reset, 1 at the first FETCH.
  int cyc;
  always @(posedge clk) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  logic [25:0] ctl;
  assign ctl = {D_Addr, D_wr, RF_s, RF_W_addr, RF_W_en, RF_Ra_addr, RF_Rb_addr, Alu_s0};

  function automatic logic [25:0] mk(input logic [7:0] da, input logic dw, input logic s,
                                     input logic [3:0] wa, input logic we, input logic [3:0] ra,
                                     input logic [3:0] rb, input logic [2:0] alu);
    return {da, dw, s, wa, we, ra, rb, alu};
  endfunction

  typedef struct {
    string       name;
    int          cyc;
    logic [25:0] ctl;
  } exp_t;

  exp_t sb[$];
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every write-enable pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (D_wr || RF_W_en) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_pulse: got ctl=%h at cyc %0d, expected no pulse", ctl, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (ctl !== e.ctl || cyc != e.cyc) begin
          failures++;
          $display("FAIL %s: got ctl=%h cyc=%0d expected ctl=%h cyc=%0d",
                   e.name, ctl, cyc, e.ctl, e.cyc);
        end
      end
    end
  end

  // Bounded wait until a given cycle index is visible at a negedge.
  task automatic at_cyc(input int n);
    int guard = 0;
    while (cyc != n && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    if (cyc != n) begin
      checks++;
      failures++;
      $display("FAIL timeout: cyc=%0d expected %0d", cyc, n);
    end
  endtask

  task automatic fill_rom(input logic [15:0] v);
    for (int i = 0; i < 128; i++) rom[i] = v;
  endtask

  initial begin
    reset = 1'b1;
    fill_rom(16'h0000);
    repeat (3) @(negedge clk);
    chk("reset_state", 32'(state_out), 32'd0);
    chk("reset_pc",    32'(PC_out),    32'd0);
    chk("reset_ir",    32'(IR_out),    32'd0);
    chk("reset_ctl",   32'(ctl),       32'd0);

    // Program 1: LOAD 27->R1, LOAD 42->R2, ADD R1+R2->R3, SUB R1-R2->R5, HALT at 4
    rom[0] = 16'h21B1;
    rom[1] = 16'h22A2;
    rom[2] = 16'h3123;
    rom[3] = 16'h4125;
    rom[4] = 16'h5000;
    sb.push_back('{"load27", 4,  mk(8'd27, 0, 1, 4'd1, 1, 4'd0, 4'd0, 3'b000)});
    sb.push_back('{"load42", 8,  mk(8'd42, 0, 1, 4'd2, 1, 4'd0, 4'd0, 3'b000)});
    sb.push_back('{"add",    11, mk(8'd0,  0, 0, 4'd3, 1, 4'd1, 4'd2, 3'b001)});
    sb.push_back('{"sub",    14, mk(8'd0,  0, 0, 4'd5, 1, 4'd1, 4'd2, 3'b010)});
    @(negedge clk);
    reset = 1'b0;
    at_cyc(2);
    chk("decode_state", 32'(state_out), 32'd2);
    chk("fetched_ir",   32'(IR_out),    32'h21B1);
    chk("pc_after_fetch", 32'(PC_out),  32'd1);
    at_cyc(3);
    chk("load_a_ctl", 32'(ctl), 32'(mk(8'd27, 0, 1, 4'd1, 0, 4'd0, 4'd0, 3'b000)));
    at_cyc(17);
    for (int i = 0; i < 22; i++) begin
      chk("halt_state", 32'(state_out), 32'd9);
      chk("halt_pc",    32'(PC_out),    32'd5);
      chk("halt_ir",    32'(IR_out),    32'h5000);
      chk("halt_ctl",   32'(ctl),       32'd0);
      @(negedge clk);
    end

    // Program 2: STORE 1FA3, opcode F as NOOP, then NOOPs through the PC wrap
    reset = 1'b1;
    @(negedge clk);
    fill_rom(16'h0000);
    rom[0] = 16'h1FA3;
    rom[1] = 16'hF000;
    sb.push_back('{"store", 3, mk(8'hFA, 1, 0, 4'd0, 0, 4'd3, 4'd0, 3'b000)});
    @(negedge clk);
    chk("reset_from_halt", 32'(state_out), 32'd0);
    reset = 1'b0;
    at_cyc(6);
    chk("opF_noop_state", 32'(state_out), 32'd3);
    chk("opF_ir",         32'(IR_out),    32'hF000);
    at_cyc(7);
    chk("opF_next_fetch", 32'(state_out), 32'd1);
    at_cyc(382);
    chk("fetch127_state", 32'(state_out), 32'd1);
    chk("fetch127_pc",    32'(PC_out),    32'd127);
    at_cyc(383);
    chk("pc_wrap",        32'(PC_out),    32'd0);

    // Program 3: reset asserted while a LOAD is in LOAD_A
    reset = 1'b1;
    @(negedge clk);
    fill_rom(16'h0000);
    rom[0] = 16'h21B1;
    @(negedge clk);
    reset = 1'b0;
    at_cyc(3);
    chk("mid_load_state", 32'(state_out), 32'd4);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_state", 32'(state_out), 32'd0);
    chk("abort_pc",    32'(PC_out),    32'd0);
    chk("abort_ir",    32'(IR_out),    32'd0);
    for (int i = 0; i < 3; i++) begin
      chk("abort_no_wen", 32'(RF_W_en), 32'd0);
      @(negedge clk);
    end

    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog in case the stimulus thread stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
